// File: rtl/lsu_ctrl_if.sv
// Bus bundle between lsu_ctrl and its neighbours: EXU request/response plus the data-memory AR/R/AW/W/B channels.
// Latency: none (wires only).
// Backpressure: valid/ready on every channel; the modports only fix signal directions.
// Ports (master = the LSU itself, slave = the EXU and memory side):
//   req_*        EXU -> LSU access request (valid/ready, wen, op, addr, wdata)
//   resp_*       LSU -> EXU result (valid/ready, rdata, err)
//   ar*/r*       read address / read data channels
//   aw*/w*/b*    write address / write data / write response channels
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  req_valid, req_wen, req_op, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output araddr, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready,
      output awaddr, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      output req_valid, req_wen, req_op, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  araddr, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready,
      input  awaddr, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time, aligns address/data/strobe, runs AR/R or AW/W/B, extends load data.
// Latency: zero-wait load is accept T, arvalid T+1, rvalid seen T+2, resp_valid T+3; all outputs registered.
// Backpressure: req_ready only in IDLE; resp_valid held until resp_ready; TIMEOUT wait cycles per channel abort with err.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-high reset; aborts any access without a response
//   bus     lsu_ctrl_if.master: EXU req/resp plus memory AR/R/AW/W/B channels
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   lsu_ctrl_if.master    bus
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_e;

   localparam bit               TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_e            state_q;
   logic [2:0]        op_q;
   logic [1:0]        pos_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;
   logic [31:0]       araddr_q;
   logic              arvalid_q;
   logic              rready_q;
   logic [31:0]       awaddr_q;
   logic              awvalid_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              wvalid_q;
   logic              bready_q;

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.araddr     = araddr_q;
   assign bus.arvalid    = arvalid_q;
   assign bus.rready     = rready_q;
   assign bus.awaddr     = awaddr_q;
   assign bus.awvalid    = awvalid_q;
   assign bus.wdata      = wdata_q;
   assign bus.wstrb      = wstrb_q;
   assign bus.wvalid     = wvalid_q;
   assign bus.bready     = bready_q;

   // Request decode: legality, alignment and store lane placement.
   logic [1:0]  req_pos;
   logic        req_bad_d;
   logic [3:0]  wstrb_d;
   logic [31:0] wdata_d;

   assign req_pos = bus.req_addr[1:0];
   assign wdata_d = bus.req_wdata << {req_pos, 3'b000};

   always_comb begin
      logic illegal;
      logic misal;
      illegal = 1'b0;
      misal   = 1'b0;
      wstrb_d = 4'b1111;
      if (bus.req_wen) illegal = (bus.req_op > 3'd2);
      else             illegal = (bus.req_op == 3'd3) || (bus.req_op == 3'd6) || (bus.req_op == 3'd7);
      // op[1:0] encodes access size for both loads and stores
      case (bus.req_op[1:0])
         2'd0: begin misal = 1'b0;            wstrb_d = 4'b0001 << req_pos; end
         2'd1: begin misal = (req_pos == 2'd3); wstrb_d = 4'b0011 << req_pos; end
         2'd2: begin misal = (req_pos != 2'd0); wstrb_d = 4'b1111;           end
         default: begin misal = 1'b0;         wstrb_d = 4'b1111;           end
      endcase
      req_bad_d = illegal | misal;
   end

   // Load extraction: shift the addressed lane down, then extend by op.
   // Word loads are always pos 0, so the shifted value is the raw word.
   logic [31:0] rshift;
   logic [31:0] load_d;

   assign rshift = bus.rdata >> {pos_q, 3'b000};

   always_comb begin
      load_d = rshift;
      case (op_q)
         3'd0:    load_d = {{24{rshift[7]}},  rshift[7:0]};
         3'd1:    load_d = {{16{rshift[15]}}, rshift[15:0]};
         3'd4:    load_d = {24'b0, rshift[7:0]};
         3'd5:    load_d = {16'b0, rshift[15:0]};
         default: load_d = rshift;
      endcase
   end

   logic timeout_hit;
   logic aw_pend;
   logic w_pend;

   assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);
   assign aw_pend     = awvalid_q && !bus.awready;
   assign w_pend      = wvalid_q  && !bus.wready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         op_q         <= '0;
         pos_q        <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         araddr_q     <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awaddr_q     <= '0;
         awvalid_q    <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q        <= bus.req_op;
                  pos_q       <= req_pos;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  if (req_bad_d) begin
                     // rejected without touching the bus
                     resp_rdata_q <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end else if (!bus.req_wen) begin
                     araddr_q  <= {bus.req_addr[31:2], 2'b00};
                     arvalid_q <= 1'b1;
                     state_q   <= RADDR;
                  end else begin
                     awaddr_q  <= {bus.req_addr[31:2], 2'b00};
                     wdata_q   <= wdata_d;
                     wstrb_q   <= wstrb_d;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WRITE;
                  end
               end
            end
            RADDR: begin
               if (bus.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= RDATA;
               end else if (timeout_hit) begin
                  arvalid_q    <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RDATA: begin
               if (bus.rvalid) begin
                  rready_q     <= 1'b0;
                  resp_rdata_q <= (bus.rresp != 2'b00) ? 32'h0 : load_d;
                  resp_err_q   <= (bus.rresp != 2'b00);
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (timeout_hit) begin
                  rready_q     <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WRITE: begin
               // AW and W complete independently; leave once neither is pending.
               if (!aw_pend && !w_pend) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= WRESP;
               end else if (timeout_hit) begin
                  awvalid_q    <= 1'b0;
                  wvalid_q     <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  if (bus.awready) awvalid_q <= 1'b0;
                  if (bus.wready)  wvalid_q  <= 1'b0;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WRESP: begin
               if (bus.bvalid) begin
                  bready_q     <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= (bus.bresp != 2'b00);
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (timeout_hit) begin
                  bready_q     <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q      <= IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               arvalid_q    <= 1'b0;
               rready_q     <= 1'b0;
               awvalid_q    <= 1'b0;
               wvalid_q     <= 1'b0;
               bready_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed corner cases then a random load/store stream.
// Memory is a byte array answered with per-channel delays; expectations come from a separate byte-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_ctrl;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_ctrl_if bus ();

   lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   logic [7:0] mem     [64];   // what the bus actually holds
   logic [7:0] ref_mem [64];   // what the spec says it should hold

   // observations from the most recent access
   logic [31:0] o_rdata;
   logic        o_err;
   logic [31:0] o_wdata;
   logic [3:0]  o_wstrb;
   int          o_arv, o_awhs, o_whs, o_bhs;
   bit          o_addr_ok, o_stable, o_rdy_low, o_done;

   task automatic idle_bus();
      bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
      bus.resp_ready = 0;
   endtask

   task automatic set_word(input int a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         mem[a + i]     = v[8*i +: 8];
         ref_mem[a + i] = v[8*i +: 8];
      end
   endtask

   function automatic int acc_size(input logic [2:0] op);
      return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit exp_bad(input bit wen, input logic [2:0] op, input logic [1:0] pos);
      int n;
      if (wen && op > 3'd2) return 1;
      if (!wen && (op == 3'd3 || op == 3'd6 || op == 3'd7)) return 1;
      n = acc_size(op);
      if (n == 2 && pos == 2'd3) return 1;
      if (n == 4 && pos != 2'd0) return 1;
      return 0;
   endfunction

   // Value of an n-byte little-endian load at byte a, sign-extended arithmetically for ops 0/1.
   function automatic logic [31:0] exp_load(input logic [2:0] op, input int a);
      longint v = 0;
      int n = acc_size(op);
      for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8*i);
      if (!op[2] && n < 4 && v >= (64'd1 << (8*n - 1))) v -= (64'd1 << (8*n));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] wd);
      for (int i = 0; i < acc_size(op); i++) ref_mem[a + i] = wd[8*i +: 8];
   endtask

   task automatic access(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int d_ar, input int d_r, input int d_aw,
                         input int d_w, input int d_b, input logic [1:0] rsp, input int hold);
      int ar_s = 0, r_s = 0, aw_s = 0, w_s = 0, b_s = 0, rs_s = 0, cyc = 0;
      bit seen = 0, fin = 0;
      int wb = {26'b0, addr[5:2], 2'b00};
      logic [31:0] a_w = {addr[31:2], 2'b00};
      o_arv = 0; o_awhs = 0; o_whs = 0; o_bhs = 0;
      o_addr_ok = 1; o_stable = 1; o_rdy_low = 1;
      o_rdata = 'x; o_err = 'x;
      while (!bus.req_ready && cyc < 50) begin @(negedge clk); cyc++; end
      check("req_ready_before_req", bus.req_ready, 1);
      bus.req_valid = 1; bus.req_wen = wen; bus.req_op = op;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(negedge clk);
      bus.req_valid = 0;
      for (cyc = 0; cyc < 100 && !fin; cyc++) begin
         idle_bus();
         if (bus.arvalid) begin
            o_arv++;
            if (bus.araddr !== a_w) o_addr_ok = 0;
            bus.arready = (ar_s >= d_ar);
            ar_s++;
         end
         if (bus.rready) begin
            if (r_s >= d_r) begin
               bus.rvalid = 1; bus.rresp = rsp;
               bus.rdata = {mem[wb+3], mem[wb+2], mem[wb+1], mem[wb]};
            end
            r_s++;
         end
         if (bus.awvalid) begin
            if (bus.awaddr !== a_w) o_addr_ok = 0;
            if (aw_s >= d_aw) begin bus.awready = 1; o_awhs++; end
            aw_s++;
         end
         if (bus.wvalid) begin
            if (w_s >= d_w) begin
               bus.wready = 1; o_whs++;
               o_wdata = bus.wdata; o_wstrb = bus.wstrb;
               if (rsp == 2'b00)
                  for (int i = 0; i < 4; i++)
                     if (bus.wstrb[i]) mem[wb + i] = bus.wdata[8*i +: 8];
            end
            w_s++;
         end
         if (bus.bready) begin
            if (b_s >= d_b) begin bus.bvalid = 1; bus.bresp = rsp; o_bhs++; end
            b_s++;
         end
         if (bus.resp_valid) begin
            if (!seen) begin
               seen = 1; o_rdata = bus.resp_rdata; o_err = bus.resp_err;
            end else if (bus.resp_rdata !== o_rdata || bus.resp_err !== o_err) o_stable = 0;
            if (bus.req_ready) o_rdy_low = 0;
            bus.resp_ready = (rs_s >= hold);
            if (bus.resp_ready) fin = 1;
            rs_s++;
         end
         @(negedge clk);
      end
      idle_bus();
      o_done = fin;
      check("access_completes", {31'b0, fin}, 1);
   endtask

   initial begin
      bit ok;
      logic [31:0] e;
      rst = 1;
      bus.req_valid = 0; bus.req_wen = 0; bus.req_op = '0;
      bus.req_addr = '0; bus.req_wdata = '0;
      idle_bus();
      for (int i = 0; i < 64; i++) begin
         mem[i] = 8'($urandom); ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);

      // reset state
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_valids", {bus.resp_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
      check("rst_resp", {bus.resp_err, bus.resp_rdata}, 0);
      check("rst_addr", bus.araddr | bus.awaddr | bus.wdata | {28'b0, bus.wstrb}, 0);
      rst = 0;
      @(negedge clk);

      // lb / lbu at pos 3
      set_word(6'h10, 32'h80112233);
      access(0, 3'd0, 32'h5000_0013, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      check("lb_data", o_rdata, 32'hFFFFFF80);
      check("lb_err", o_err, 0);
      check("lb_araddr", o_addr_ok, 1);
      check("lb_ar_cycles", o_arv, 1);
      access(0, 3'd4, 32'h5000_0013, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      check("lbu_data", o_rdata, 32'h00000080);

      // lh pos 1, lh misaligned
      set_word(6'h20, 32'h12F00D34);
      access(0, 3'd1, 32'h5000_0021, 0, 1, 1, 0, 0, 0, 2'b00, 0);
      check("lh_data", o_rdata, 32'hFFFFF00D);
      access(0, 3'd1, 32'h5000_0023, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      check("lh_misal_err", o_err, 1);
      check("lh_misal_data", o_rdata, 0);
      check("lh_misal_no_ar", o_arv, 0);

      // sh pos 2, W accepted 3 cycles after AW
      access(1, 3'd1, 32'h5000_002A, 32'h0000ABCD, 0, 0, 0, 3, 0, 2'b00, 0);
      ref_store(3'd1, 6'h2A, 32'h0000ABCD);
      check("sh_wdata", o_wdata, 32'hABCD0000);
      check("sh_wstrb", o_wstrb, 4'b1100);
      check("sh_b_count", o_bhs, 1);
      check("sh_err", o_err, 0);
      check("sh_rdata", o_rdata, 0);
      check("sh_awaddr", o_addr_ok, 1);

      // AR never accepted -> timeout, then a normal lw
      access(0, 3'd2, 32'h5000_0030, 0, 1000, 0, 0, 0, 0, 2'b00, 0);
      check("to_err", o_err, 1);
      check("to_data", o_rdata, 0);
      check("to_ar_cycles_in_range", (o_arv >= TO && o_arv <= TO + 1) ? 1 : 0, 1);
      set_word(6'h30, 32'hCAFEF00D);
      access(0, 3'd2, 32'h5000_0030, 0, 0, 2, 0, 0, 0, 2'b00, 0);
      check("lw_after_to_data", o_rdata, 32'hCAFEF00D);
      check("lw_after_to_err", o_err, 0);

      // response held off for 5 cycles
      access(0, 3'd5, 32'h5000_0022, 0, 0, 0, 0, 0, 0, 2'b00, 5);
      check("hold_stable", o_stable, 1);
      check("hold_req_ready_low", o_rdy_low, 1);
      check("hold_data", o_rdata, 32'h000012F0);
      check("req_ready_after_resp", bus.req_ready, 1);

      // reset while in RDATA
      bus.req_valid = 1; bus.req_wen = 0; bus.req_op = 3'd2; bus.req_addr = 32'h5000_0004;
      @(negedge clk);
      bus.req_valid = 0;
      check("rstmid_arvalid", bus.arvalid, 1);
      bus.arready = 1;
      @(negedge clk);
      bus.arready = 0;
      check("rstmid_rready", bus.rready, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rstmid_idle", {bus.req_ready, bus.resp_valid, bus.rready, bus.arvalid}, 4'b1000);
      ok = 1;
      bus.rvalid = 1; bus.rdata = 32'h12345678;
      repeat (3) begin
         @(negedge clk);
         if (bus.resp_valid) ok = 0;
      end
      bus.rvalid = 0;
      check("rstmid_no_resp", ok, 1);

      // store bus error, illegal ops
      access(1, 3'd2, 32'h5000_0034, 32'h11223344, 0, 0, 1, 0, 1, 2'b10, 0);
      check("sw_berr", o_err, 1);
      check("sw_berr_b_count", o_bhs, 1);
      access(0, 3'd3, 32'h5000_0000, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      check("ld_op3_err", o_err, 1);
      check("ld_op3_no_ar", o_arv, 0);
      access(1, 3'd4, 32'h5000_0000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 2'b00, 0);
      check("st_op4_err", o_err, 1);
      check("st_op4_no_aw", o_awhs + o_whs, 0);

      // random stream
      for (int k = 0; k < 100; k++) begin
         bit wen = 1'($urandom);
         logic [2:0] op;
         logic [31:0] addr = 32'h5000_0000 | ($urandom & 32'h3F);
         logic [31:0] wd = $urandom;
         bit bad;
         int a = {26'b0, addr[5:0]};
         int wb = {26'b0, addr[5:2], 2'b00};
         if (wen) op = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 5))
               0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2;
               3: op = 3'd4; 4: op = 3'd5; default: op = 3'd3;
            endcase
         end
         bad = exp_bad(wen, op, addr[1:0]);
         e = (wen || bad) ? 32'h0 : exp_load(op, a);
         access(wen, op, addr, wd, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                2'b00, $urandom_range(0, 2));
         check($sformatf("rnd%0d_err", k), o_err, bad);
         check($sformatf("rnd%0d_rdata", k), o_rdata, e);
         if (wen && !bad) begin
            ref_store(op, a, wd);
            check($sformatf("rnd%0d_memword", k),
                  {mem[wb+3], mem[wb+2], mem[wb+1], mem[wb]},
                  {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
